// File: rtl/mux6_rr_arbiter.sv
// mux6_rr_arbiter: round-robin 6:1 byte mux scheduler with registered valid/ready output; define MUX6_ARB_BURST_EN for burst grants
module mux6_rr_arbiter #(
  parameter int WIDTH = 8,
  parameter int BURST_MAX = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [5:0]       req,
  input  logic [WIDTH-1:0] E1,
  input  logic [WIDTH-1:0] E2,
  input  logic [WIDTH-1:0] E3,
  input  logic [WIDTH-1:0] E4,
  input  logic [WIDTH-1:0] E5,
  input  logic [WIDTH-1:0] E6,
  output logic [5:0]       gnt,
  output logic [2:0]       sel,
  output logic [WIDTH-1:0] salida,
  output logic             salida_valid,
  input  logic             salida_ready
);
  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] FULL = 1'b1;
  logic [0:0] state_q, state_d;
  logic [WIDTH-1:0] salida_q, salida_d;
  logic [2:0] sel_q, sel_d, ptr_q, ptr_d, w, w_nxt;
  logic [WIDTH-1:0] e [6];
  logic free, go;
  always_comb begin
    e[0] = E1;
    e[1] = E2;
    e[2] = E3;
    e[3] = E4;
    e[4] = E5;
    e[5] = E6;
  end
  always_comb begin
    logic [2:0] idx;
    idx = '0;
    w = ptr_q;
    for (int k = 5; k >= 0; k--) begin
      idx = 3'((int'(ptr_q) + k) % 6);
      w = req[idx] ? idx : w;
    end
  end
  assign free = state_q == IDLE || salida_ready;
  assign go = free && !rst && |req;
  assign gnt = go ? 6'(1) << w : '0;
  assign w_nxt = w == 3'd5 ? 3'd0 : w + 3'd1;
  assign state_d = go ? FULL : free ? IDLE : state_q;
  assign salida_d = go ? e[w] : salida_q;
  assign sel_d = go ? w : sel_q;
`ifdef MUX6_ARB_BURST_EN
  localparam int CW = $clog2(BURST_MAX + 1);
  logic [CW-1:0] cnt_q, cnt_d, base;
  logic more;
  always_comb begin
    base = w == ptr_q ? cnt_q : '0;
    more = int'(base) + 1 < BURST_MAX;
    ptr_d = go ? (more ? w : w_nxt) : ptr_q;
    cnt_d = go ? (more ? base + 1'b1 : '0) : cnt_q;
  end
  always_ff @(posedge clk) cnt_q <= rst ? '0 : cnt_d;
`else
  assign ptr_d = go ? w_nxt : ptr_q;
`endif
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      salida_q <= '0;
      sel_q <= '0;
      ptr_q <= '0;
    end else begin
      state_q <= state_d;
      salida_q <= salida_d;
      sel_q <= sel_d;
      ptr_q <= ptr_d;
    end
  end
  assign salida = salida_q;
  assign sel = sel_q;
  assign salida_valid = state_q == FULL;
endmodule

// File: tb/tb_mux6_rr_arbiter.sv
// tb_mux6_rr_arbiter: randomized and directed checks of mux6_rr_arbiter against a grant-history model
module tb_mux6_rr_arbiter;
`ifdef MUX6_ARB_BURST_EN
  localparam int BMAX = 4;
`else
  localparam int BMAX = 1;
`endif
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [5:0] req = '0;
  logic salida_ready = 1'b1;
  logic [7:0] d [6];
  logic [5:0] gnt;
  logic [2:0] sel;
  logic [7:0] salida;
  logic salida_valid;
  int n_chk = 0;
  int n_fail = 0;
  int m_last, m_run, m_sel;
  logic m_valid;
  logic [7:0] m_salida;

  mux6_rr_arbiter #(.WIDTH(8), .BURST_MAX(4)) dut (
    .clk(clk), .rst(rst), .req(req),
    .E1(d[0]), .E2(d[1]), .E3(d[2]), .E4(d[3]), .E5(d[4]), .E6(d[5]),
    .gnt(gnt), .sel(sel), .salida(salida), .salida_valid(salida_valid),
    .salida_ready(salida_ready)
  );

  always #5 clk = ~clk;

  // Priority starts at the last winner while its burst is unfinished, else just after it.
  function automatic int exp_w();
    int start;
    start = (m_run > 0 && m_run < BMAX) ? m_last : (m_last + 1) % 6;
    for (int k = 0; k < 6; k++)
      if (req[(start + k) % 6]) return (start + k) % 6;
    return -1;
  endfunction

  function automatic logic [5:0] exp_gnt();
    int wv;
    wv = exp_w();
    if (rst || wv < 0 || (m_valid && !salida_ready)) return 6'b0;
    return 6'(1) << wv;
  endfunction

  task automatic model_reset();
    m_last = 5;
    m_run = 0;
    m_valid = 1'b0;
    m_salida = '0;
    m_sel = 0;
  endtask

  task automatic tick();
    int wv;
    logic fr;
    logic [7:0] dv;
    wv = exp_w();
    fr = !m_valid || salida_ready;
    dv = wv >= 0 ? d[wv] : 8'h00;
    @(posedge clk);
    if (rst) model_reset();
    else if (fr && wv >= 0) begin
      m_salida = dv;
      m_sel = wv;
      m_valid = 1'b1;
      m_run = (wv == m_last && m_run < BMAX) ? m_run + 1 : 1;
      m_last = wv;
    end else if (fr) m_valid = 1'b0;
    #1;
  endtask

  task automatic set_data_default();
    for (int i = 0; i < 6; i++) d[i] = 8'hE1 + 8'(i);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    req = 6'h3f;
    #1;
    n_chk++;
    if (gnt !== 6'b0) begin n_fail++; $display("FAIL reset_gnt got %b exp 000000", gnt); end
    tick();
    n_chk++;
    if ({salida_valid, sel, salida} !== 12'h000) begin
      n_fail++; $display("FAIL reset_out got v=%b sel=%0d salida=%h exp 0/0/00", salida_valid, sel, salida);
    end
    rst = 1'b0;
  endtask

  task automatic run_pattern(input string nm, input logic [5:0] r, input int cycles);
    logic [5:0] eg;
    req = r;
    for (int c = 0; c < cycles; c++) begin
      #1;
      eg = exp_gnt();
      n_chk++;
      if (gnt !== eg) begin n_fail++; $display("FAIL %s gnt cyc%0d got %b exp %b", nm, c, gnt, eg); end
      tick();
      n_chk++;
      if ({salida_valid, sel, salida} !== {m_valid, 3'(m_sel), m_salida}) begin
        n_fail++;
        $display("FAIL %s out cyc%0d got v=%b sel=%0d salida=%h exp v=%b sel=%0d salida=%h",
                 nm, c, salida_valid, sel, salida, m_valid, m_sel, m_salida);
      end
    end
  endtask

  task automatic test_rotation();
    logic [5:0] seq_exp [7];
    set_data_default();
    salida_ready = 1'b1;
    req = 6'h3f;
    for (int c = 0; c < 7; c++) begin
      #1;
      seq_exp[c] = exp_gnt();
`ifndef MUX6_ARB_BURST_EN
      n_chk++;
      if (seq_exp[c] !== 6'(1) << (c % 6)) begin
        n_fail++; $display("FAIL rotation_model cyc%0d got %b exp %b", c, seq_exp[c], 6'(1) << (c % 6));
      end
`endif
      n_chk++;
      if (gnt !== seq_exp[c]) begin n_fail++; $display("FAIL rotation gnt cyc%0d got %b exp %b", c, gnt, seq_exp[c]); end
      tick();
      n_chk++;
      if ({salida_valid, sel, salida} !== {m_valid, 3'(m_sel), m_salida}) begin
        n_fail++; $display("FAIL rotation out cyc%0d got v=%b sel=%0d salida=%h exp v=%b sel=%0d salida=%h",
                           c, salida_valid, sel, salida, m_valid, m_sel, m_salida);
      end
    end
  endtask

  task automatic test_stall();
    req = 6'b000001;
    salida_ready = 1'b1;
    run_pattern("stall_fill", 6'b000001, 1);
    salida_ready = 1'b0;
    run_pattern("stall_hold", 6'b000001, 3);
    n_chk++;
    if (salida !== 8'hE1 || !salida_valid) begin
      n_fail++; $display("FAIL stall_data got v=%b salida=%h exp v=1 salida=e1", salida_valid, salida);
    end
    salida_ready = 1'b1;
    run_pattern("stall_release", 6'b000001, 2);
  endtask

  task automatic test_reset_mid();
    salida_ready = 1'b1;
    run_pattern("rmid_fill", 6'b001000, 1);
    n_chk++;
    if (sel !== 3'd3 || !salida_valid) begin
      n_fail++; $display("FAIL rmid_pre got v=%b sel=%0d exp v=1 sel=3", salida_valid, sel);
    end
    rst = 1'b1;
    run_pattern("rmid_rst", 6'b001000, 1);
    rst = 1'b0;
    req = 6'b001010;
    #1;
    n_chk++;
    if (gnt !== 6'b000010) begin n_fail++; $display("FAIL rmid_first got %b exp 000010", gnt); end
    run_pattern("rmid_after", 6'b001010, 4);
  endtask

  task automatic test_idle();
    salida_ready = 1'b1;
    run_pattern("idle_pre", 6'b010000, 1);
    run_pattern("idle", 6'b000000, 10);
    n_chk++;
    if (salida_valid !== 1'b0 || sel !== 3'd4 || salida !== d[4]) begin
      n_fail++; $display("FAIL idle_hold got v=%b sel=%0d salida=%h exp v=0 sel=4 salida=%h", salida_valid, sel, salida, d[4]);
    end
  endtask

`ifdef MUX6_ARB_BURST_EN
  task automatic test_burst();
    rst = 1'b1;
    run_pattern("burst_rst", 6'h3f, 1);
    rst = 1'b0;
    salida_ready = 1'b1;
    run_pattern("burst_full", 6'h3f, 10);
    rst = 1'b1;
    run_pattern("burst_rst2", 6'h3f, 1);
    rst = 1'b0;
    run_pattern("burst_two", 6'h3f, 2);
    req = 6'h3e;
    #1;
    n_chk++;
    if (gnt !== 6'b000010) begin n_fail++; $display("FAIL burst_drop got %b exp 000010", gnt); end
    run_pattern("burst_after", 6'h3e, 6);
  endtask
`endif

  task automatic test_random();
    for (int c = 0; c < 400; c++) begin
      for (int i = 0; i < 6; i++) d[i] = 8'($urandom);
      salida_ready = ($urandom % 4) != 0;
      rst = ($urandom % 60) == 0;
      run_pattern("random", 6'($urandom), 1);
    end
    rst = 1'b0;
  endtask

  initial begin
    model_reset();
    set_data_default();
    test_reset();
    test_rotation();
    run_pattern("wrap", 6'b100001, 6);
    test_stall();
    test_reset_mid();
    test_idle();
`ifdef MUX6_ARB_BURST_EN
    test_burst();
`endif
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
